dut_mem_arbiter: RTL and testbench

DUT_MEM_ARBITER -- requirements
Module: dut_mem_arbiter

---
 rtl/dut_mem_arbiter_if.sv | 42 ++++
 rtl/dut_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dut_mem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dut_mem_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port memory arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the memory.
interface dut_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic                  req1;
  logic                  wr_rd0;
  logic                  wr_rd1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  mem_sel;
  logic                  mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  busy;

  modport slave (
    input  req0, req1, wr_rd0, wr_rd1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata, mem_ready,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_sel, mem_wr_rd, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, req1, wr_rd0, wr_rd1, addr0, addr1, wdata0, wdata1,
    output mem_rdata, mem_ready,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_sel, mem_wr_rd, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dut_mem_arbiter.sv
// Round-robin arbiter giving two requesters a single-outstanding memory port; grant one cycle after
// an idle request, read data four cycles after it; mem_ready low stalls ISSUE with grant and command held.
module dut_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  dut_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RD_W1 = 2'd2,
    RD_W2 = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  mem_sel_q, mem_sel_d;
  logic                  mem_wr_rd_q, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;

  logic                  any_req;
  logic                  win;
  logic                  win_wr_rd;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = bus.req1;
    if (bus.req0 && bus.req1) begin
      win = ptr_q;
    end
    win_wr_rd = win ? bus.wr_rd1 : bus.wr_rd0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_sel_d   = mem_sel_q;
    mem_wr_rd_d = mem_wr_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = ISSUE;
          owner_d     = win;
          ptr_d       = ~win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          mem_sel_d   = 1'b1;
          mem_wr_rd_d = win_wr_rd;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
        end
      end
      ISSUE: begin
        // Without mem_ready every registered output simply holds.
        if (bus.mem_ready) begin
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          mem_sel_d = 1'b0;
          state_d   = mem_wr_rd_q ? IDLE : RD_W1;
        end
      end
      RD_W1: begin
        state_d = RD_W2;
      end
      RD_W2: begin
        state_d = IDLE;
        if (owner_q) begin
          rdata1_d  = bus.mem_rdata;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.mem_rdata;
          rvalid0_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_sel_q   <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_sel_q   <= mem_sel_d;
      mem_wr_rd_q <= mem_wr_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_wr_rd = mem_wr_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) !(gnt0_q && gnt1_q));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (reset) !(rvalid0_q && rvalid1_q));
  a_sel_in_issue: assert property (@(posedge clk) disable iff (reset) mem_sel_q == (state_q == ISSUE));

endmodule

// File: tb/tb_dut_mem_arbiter.sv
// Directed and randomized checks of the two-port round-robin memory arbiter.
module tb_dut_mem_arbiter;

  logic clk;
  logic reset;
  logic mem_clear;
  int   total;
  int   bad;
  int   issue_cnt;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  dut_mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  dut_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: all locations read 16'h5678 after a clear; read data stays registered until the next read.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h5678;
    end else if (bus.mem_sel && bus.mem_ready) begin
      issue_cnt <= issue_cnt + 1;
      if (bus.mem_wr_rd) mem[bus.mem_addr] <= bus.mem_wdata;
      else               bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit clr);
    reset     = 1'b1;
    mem_clear = clr;
    tick();
    reset     = 1'b0;
    mem_clear = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    mem_clear = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_sel, bus.mem_wr_rd, bus.busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_sel, bus.mem_wr_rd, bus.busy});
    end
    total++;
    if ({bus.rdata0, bus.rdata1} !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata got=%h exp=0", {bus.rdata0, bus.rdata1});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata} !== 24'h0) begin
      bad++;
      $display("FAIL reset_mem_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata});
    end
    reset     = 1'b0;
    mem_clear = 1'b0;
    tick();
    total++;
    if ({bus.busy, bus.mem_sel} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=00", {bus.busy, bus.mem_sel});
    end
  endtask

  task automatic test_write_read;
    bus.req0 = 1'b1; bus.wr_rd0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 16'hABCD;
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.mem_sel, bus.mem_wr_rd, bus.busy} !== 5'b10111) begin
      bad++;
      $display("FAIL wr_grant got=%b exp=10111", {bus.gnt0, bus.gnt1, bus.mem_sel, bus.mem_wr_rd, bus.busy});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata} !== 24'h10ABCD) begin
      bad++;
      $display("FAIL wr_mem_bus got=%h exp=10abcd", {bus.mem_addr, bus.mem_wdata});
    end
    bus.req0 = 1'b0;
    tick();
    total++;
    if ({bus.gnt0, bus.mem_sel, bus.busy} !== 3'b000) begin
      bad++;
      $display("FAIL wr_done got=%b exp=000", {bus.gnt0, bus.mem_sel, bus.busy});
    end
    bus.req1 = 1'b1; bus.wr_rd1 = 1'b0; bus.addr1 = 8'h10;
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.mem_sel, bus.mem_wr_rd} !== 4'b0110) begin
      bad++;
      $display("FAIL rd_grant got=%b exp=0110", {bus.gnt0, bus.gnt1, bus.mem_sel, bus.mem_wr_rd});
    end
    bus.req1 = 1'b0;
    tick();
    total++;
    if ({bus.mem_sel, bus.rvalid1, bus.busy} !== 3'b001) begin
      bad++;
      $display("FAIL rd_w1 got=%b exp=001", {bus.mem_sel, bus.rvalid1, bus.busy});
    end
    tick();
    tick();
    total++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b01 || bus.rdata1 !== 16'hABCD) begin
      bad++;
      $display("FAIL rd_data got=%b/%h exp=01/abcd", {bus.rvalid0, bus.rvalid1}, bus.rdata1);
    end
    total++;
    if (bus.rdata0 !== 16'h0) begin
      bad++;
      $display("FAIL rd_nonowner got=%h exp=0000", bus.rdata0);
    end
    tick();
    total++;
    if (bus.rvalid1 !== 1'b0 || bus.rdata1 !== 16'hABCD) begin
      bad++;
      $display("FAIL rd_hold got=%b/%h exp=0/abcd", bus.rvalid1, bus.rdata1);
    end
  endtask

  task automatic test_simul_reads;
    do_reset(1'b0);
    bus.req0 = 1'b1; bus.wr_rd0 = 1'b0; bus.addr0 = 8'h10;
    bus.req1 = 1'b1; bus.wr_rd1 = 1'b0; bus.addr1 = 8'h11;
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10 || bus.mem_addr !== 8'h10) begin
      bad++;
      $display("FAIL sim_first got=%b/%h exp=10/10", {bus.gnt0, bus.gnt1}, bus.mem_addr);
    end
    tick(); tick(); tick();
    total++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b10 || bus.rdata0 !== 16'hABCD) begin
      bad++;
      $display("FAIL sim_rv0 got=%b/%h exp=10/abcd", {bus.rvalid0, bus.rvalid1}, bus.rdata0);
    end
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01 || bus.mem_addr !== 8'h11) begin
      bad++;
      $display("FAIL sim_second got=%b/%h exp=01/11", {bus.gnt0, bus.gnt1}, bus.mem_addr);
    end
    tick(); tick(); tick();
    total++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b01 || bus.rdata1 !== 16'h5678) begin
      bad++;
      $display("FAIL sim_rv1 got=%b/%h exp=01/5678", {bus.rvalid0, bus.rvalid1}, bus.rdata1);
    end
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL sim_alternate got=%b exp=10", {bus.gnt0, bus.gnt1});
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick(); tick(); tick();
    total++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'hABCD || bus.rdata1 !== 16'h5678) begin
      bad++;
      $display("FAIL sim_rv0b got=%b/%h/%h exp=1/abcd/5678", bus.rvalid0, bus.rdata0, bus.rdata1);
    end
    tick();
    total++;
    if ({bus.busy, bus.gnt0, bus.gnt1} !== 3'b000) begin
      bad++;
      $display("FAIL sim_idle got=%b exp=000", {bus.busy, bus.gnt0, bus.gnt1});
    end
  endtask

  task automatic test_unwritten;
    do_reset(1'b1);
    bus.req0 = 1'b1; bus.wr_rd0 = 1'b0; bus.addr0 = 8'h00;
    tick();
    bus.req0 = 1'b0;
    tick(); tick();
    total++;
    if (bus.rvalid0 !== 1'b0) begin
      bad++;
      $display("FAIL unw_early got=%b exp=0", bus.rvalid0);
    end
    tick();
    total++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h5678 || bus.rdata1 !== 16'h0) begin
      bad++;
      $display("FAIL unw_data got=%b/%h/%h exp=1/5678/0000", bus.rvalid0, bus.rdata0, bus.rdata1);
    end
  endtask

  task automatic test_ready_stall;
    int base;
    tick();
    bus.req1 = 1'b1; bus.wr_rd1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 16'h1234;
    tick();
    bus.req1      = 1'b0;
    bus.mem_ready = 1'b0;
    base          = issue_cnt;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({bus.gnt1, bus.mem_sel} !== 2'b11 || bus.mem_addr !== 8'h20 || bus.mem_wdata !== 16'h1234) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b/%h/%h exp=11/20/1234", k, {bus.gnt1, bus.mem_sel},
                 bus.mem_addr, bus.mem_wdata);
      end
      tick();
    end
    total++;
    if ({bus.gnt1, bus.mem_sel} !== 2'b11) begin
      bad++;
      $display("FAIL stall_last got=%b exp=11", {bus.gnt1, bus.mem_sel});
    end
    bus.mem_ready = 1'b1;
    tick();
    total++;
    if ({bus.gnt1, bus.mem_sel, bus.busy} !== 3'b000 || issue_cnt - base !== 1) begin
      bad++;
      $display("FAIL stall_release got=%b issues=%0d exp=000 issues=1", {bus.gnt1, bus.mem_sel, bus.busy},
               issue_cnt - base);
    end
    bus.req0 = 1'b1; bus.wr_rd0 = 1'b0; bus.addr0 = 8'h20;
    tick();
    bus.req0 = 1'b0;
    tick(); tick(); tick();
    total++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h1234) begin
      bad++;
      $display("FAIL stall_readback got=%b/%h exp=1/1234", bus.rvalid0, bus.rdata0);
    end
  endtask

  task automatic test_reset_mid_read;
    bit seen;
    bus.req0 = 1'b1; bus.wr_rd0 = 1'b0; bus.addr0 = 8'h20;
    tick();
    bus.req0 = 1'b0;
    tick();
    total++;
    if ({bus.busy, bus.mem_sel} !== 2'b10) begin
      bad++;
      $display("FAIL mid_rdw1 got=%b exp=10", {bus.busy, bus.mem_sel});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_sel, bus.mem_wr_rd, bus.busy} !== 7'b0 ||
        {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata} !== 56'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h exp=0/0",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_sel, bus.mem_wr_rd, bus.busy},
               {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata});
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.rvalid0 || bus.rvalid1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || bus.rdata0 !== 16'h0) begin
      bad++;
      $display("FAIL mid_no_rvalid got=%b/%h exp=0/0000", seen, bus.rdata0);
    end
  endtask

  task automatic test_random;
    int  issued, done, cyc, other0, other1;
    bit  pend0, pend1, rdw0, rdw1;
    logic [15:0] exp0, exp1;
    do_reset(1'b1);
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h5678;
    issued = 0; done = 0; cyc = 0; other0 = 0; other1 = 0;
    pend0 = 1'b0; pend1 = 1'b0; rdw0 = 1'b0; rdw1 = 1'b0;
    exp0 = '0; exp1 = '0;
    while ((done < 1000 || rdw0 || rdw1) && cyc < 40000) begin
      total++;
      if ((bus.gnt0 && bus.gnt1) || (bus.rvalid0 && bus.rvalid1)) begin
        bad++;
        $display("FAIL rnd_dual cyc=%0d gnt=%b rvalid=%b exp=one-hot", cyc, {bus.gnt0, bus.gnt1},
                 {bus.rvalid0, bus.rvalid1});
      end
      if (bus.gnt0 && pend0) begin
        total++;
        if (bus.mem_addr !== bus.addr0 || bus.mem_wr_rd !== bus.wr_rd0) begin
          bad++;
          $display("FAIL rnd_cmd0 got=%h/%b exp=%h/%b", bus.mem_addr, bus.mem_wr_rd, bus.addr0, bus.wr_rd0);
        end
        if (bus.wr_rd0) ref_mem[bus.addr0] = bus.wdata0;
        else begin exp0 = ref_mem[bus.addr0]; rdw0 = 1'b1; end
        pend0 = 1'b0; bus.req0 = 1'b0; done++;
        if (pend1) begin
          other1++;
          total++;
          if (other1 > 1) begin
            bad++;
            $display("FAIL rnd_starve1 got=%0d exp<=1", other1);
          end
        end
      end
      if (bus.gnt1 && pend1) begin
        total++;
        if (bus.mem_addr !== bus.addr1 || bus.mem_wr_rd !== bus.wr_rd1) begin
          bad++;
          $display("FAIL rnd_cmd1 got=%h/%b exp=%h/%b", bus.mem_addr, bus.mem_wr_rd, bus.addr1, bus.wr_rd1);
        end
        if (bus.wr_rd1) ref_mem[bus.addr1] = bus.wdata1;
        else begin exp1 = ref_mem[bus.addr1]; rdw1 = 1'b1; end
        pend1 = 1'b0; bus.req1 = 1'b0; done++;
        if (pend0) begin
          other0++;
          total++;
          if (other0 > 1) begin
            bad++;
            $display("FAIL rnd_starve0 got=%0d exp<=1", other0);
          end
        end
      end
      if (bus.rvalid0) begin
        total++;
        if (!rdw0 || bus.rdata0 !== exp0) begin
          bad++;
          $display("FAIL rnd_rdata0 got=%h exp=%h outstanding=%b", bus.rdata0, exp0, rdw0);
        end
        rdw0 = 1'b0;
      end
      if (bus.rvalid1) begin
        total++;
        if (!rdw1 || bus.rdata1 !== exp1) begin
          bad++;
          $display("FAIL rnd_rdata1 got=%h exp=%h outstanding=%b", bus.rdata1, exp1, rdw1);
        end
        rdw1 = 1'b0;
      end
      if (!pend0 && !rdw0 && !bus.gnt0 && issued < 1000 && $urandom_range(0, 3) != 0) begin
        pend0 = 1'b1; other0 = 0; issued++;
        bus.req0 = 1'b1; bus.wr_rd0 = 1'($urandom_range(0, 1));
        bus.addr0 = 8'($urandom_range(0, 15)); bus.wdata0 = 16'($urandom);
      end
      if (!pend1 && !rdw1 && !bus.gnt1 && issued < 1000 && $urandom_range(0, 3) != 0) begin
        pend1 = 1'b1; other1 = 0; issued++;
        bus.req1 = 1'b1; bus.wr_rd1 = 1'($urandom_range(0, 1));
        bus.addr1 = 8'($urandom_range(0, 15)); bus.wdata1 = 16'($urandom);
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    bus.mem_ready = 1'b1;
    total++;
    if (done !== 1000 || rdw0 || rdw1) begin
      bad++;
      $display("FAIL rnd_complete got=%0d outstanding=%b%b cyc=%0d exp=1000 outstanding=00", done, rdw0, rdw1, cyc);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    issue_cnt     = 0;
    reset         = 1'b1;
    mem_clear     = 1'b1;
    bus.req0      = 1'b0; bus.req1   = 1'b0;
    bus.wr_rd0    = 1'b0; bus.wr_rd1 = 1'b0;
    bus.addr0     = '0;   bus.addr1  = '0;
    bus.wdata0    = '0;   bus.wdata1 = '0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_write_read();
    test_simul_reads();
    test_unwritten();
    test_ready_stall();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
